gpu_rect_fill: RTL and testbench

//  Rectangle fill engine sitting directly upstream of the 1-bit 320x200 framebuffer RAM.

---
 rtl/gpu_rect_fill_if.sv | 33 +++
 rtl/gpu_rect_fill.sv | 191 +++++++++++++++++++
 tb/tb_gpu_rect_fill.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_rect_fill_if.sv
// Command and RAM port-B bundle for the rectangle fill engine.
// slave  = the fill engine (takes commands, drives the RAM requests).
// master = the environment (issues commands, owns the RAM port B).
interface gpu_rect_fill_if;
    // command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x0;
    logic [7:0] cmd_y0;
    logic [8:0] cmd_x1;
    logic [7:0] cmd_y1;
    logic [1:0] cmd_op;
    logic       busy;
    logic       done;
    // framebuffer RAM port B
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic       read_b;
    logic       write_b;
    logic       in_b;
    logic       out_b;
    logic       rdy_b;

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_op, out_b, rdy_b,
        output cmd_ready, busy, done, x_b, y_b, read_b, write_b, in_b
    );

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_op, out_b, rdy_b,
        input  cmd_ready, busy, done, x_b, y_b, read_b, write_b, in_b
    );
endinterface

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: walks a clamped rectangle row-major and issues
// per-pixel clear/set writes or invert read-modify-writes on RAM port B.
// RAM requests are combinational from state and rdy_b so that a request
// goes out in the same cycle the RAM reports idle and lasts exactly one cycle.
module gpu_rect_fill #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    gpu_rect_fill_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PIX   = 2'd1,
        S_RWAIT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_INVERT = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    state_t     state_q, state_d;
    logic [8:0] cur_x_q, cur_x_d;
    logic [7:0] cur_y_q, cur_y_d;
    logic [8:0] xl_q, xl_d;
    logic [8:0] xr_q, xr_d;
    logic [7:0] yt_q, yt_d;
    logic [7:0] yb_q, yb_d;
    logic [1:0] op_q, op_d;

    // clamped, ordered corners of the incoming command
    logic [8:0] cx0, cx1, in_xl, in_xr;
    logic [7:0] cy0, cy1, in_yt, in_yb;

    // walker step results
    logic       last_pix;
    logic [8:0] adv_x;
    logic [7:0] adv_y;

    logic accept;

    // clamp each corner to the framebuffer, then sort into left/right, top/bottom
    always_comb begin
        cx0   = (bus.cmd_x0 > X_MAX) ? X_MAX : bus.cmd_x0;
        cx1   = (bus.cmd_x1 > X_MAX) ? X_MAX : bus.cmd_x1;
        cy0   = (bus.cmd_y0 > Y_MAX) ? Y_MAX : bus.cmd_y0;
        cy1   = (bus.cmd_y1 > Y_MAX) ? Y_MAX : bus.cmd_y1;
        in_xl = (cx0 < cx1) ? cx0 : cx1;
        in_xr = (cx0 < cx1) ? cx1 : cx0;
        in_yt = (cy0 < cy1) ? cy0 : cy1;
        in_yb = (cy0 < cy1) ? cy1 : cy0;
    end

    // row-major step; the last pixel holds its position so counters stay in bounds
    always_comb begin
        last_pix = (cur_x_q == xr_q) && (cur_y_q == yb_q);
        adv_x    = cur_x_q;
        adv_y    = cur_y_q;
        if (!last_pix) begin
            if (cur_x_q == xr_q) begin
                adv_x = xl_q;
                adv_y = cur_y_q + 8'd1;
            end else begin
                adv_x = cur_x_q + 9'd1;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            xl_q    <= '0;
            xr_q    <= '0;
            yt_q    <= '0;
            yb_q    <= '0;
            op_q    <= OP_CLEAR;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            yt_q    <= yt_d;
            yb_q    <= yb_d;
            op_q    <= op_d;
        end
    end

    // next-state and walker update
    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        yt_d    = yt_q;
        yb_d    = yb_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    xl_d    = in_xl;
                    xr_d    = in_xr;
                    yt_d    = in_yt;
                    yb_d    = in_yb;
                    op_d    = bus.cmd_op;
                    cur_x_d = in_xl;
                    cur_y_d = in_yt;
                    // reserved op skips straight to the drain wait
                    state_d = (bus.cmd_op == OP_NOP) ? S_DRAIN : S_PIX;
                end
            end
            S_PIX: begin
                if (bus.rdy_b) begin
                    if (op_q == OP_INVERT) begin
                        state_d = S_RWAIT;
                    end else begin
                        cur_x_d = adv_x;
                        cur_y_d = adv_y;
                        state_d = last_pix ? S_DRAIN : S_PIX;
                    end
                end
            end
            S_RWAIT: begin
                // first idle cycle after the read carries the data and the write-back
                if (bus.rdy_b) begin
                    cur_x_d = adv_x;
                    cur_y_d = adv_y;
                    state_d = last_pix ? S_DRAIN : S_PIX;
                end
            end
            S_DRAIN: begin
                if (bus.rdy_b) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs: handshake status and single-cycle RAM requests gated by rdy_b
    always_comb begin
        bus.cmd_ready = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.done      = 1'b0;
        bus.x_b       = '0;
        bus.y_b       = '0;
        bus.read_b    = 1'b0;
        bus.write_b   = 1'b0;
        bus.in_b      = 1'b0;
        case (state_q)
            S_PIX: begin
                bus.x_b = cur_x_q;
                bus.y_b = cur_y_q;
                if (bus.rdy_b) begin
                    if (op_q == OP_INVERT) begin
                        bus.read_b = 1'b1;
                    end else begin
                        bus.write_b = 1'b1;
                        bus.in_b    = (op_q == OP_SET);
                    end
                end
            end
            S_RWAIT: begin
                bus.x_b = cur_x_q;
                bus.y_b = cur_y_q;
                if (bus.rdy_b) begin
                    bus.write_b = 1'b1;
                    bus.in_b    = ~bus.out_b;
                end
            end
            S_DRAIN: begin
                bus.done = bus.rdy_b;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed bench for gpu_rect_fill with a behavioural 320x200 port-B RAM
// (3-cycle read and write occupancy, read data valid on the first idle cycle).
module tb_gpu_rect_fill;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpu_rect_fill_if bus_if ();

    gpu_rect_fill #(.WIDTH(320), .HEIGHT(200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    bit   mem [0:63999];
    int   ram_cnt   = 0;
    logic ram_rdata = 1'b0;
    logic pre_en    = 1'b0;
    int   pre_idx   = 0;
    logic pre_val   = 1'b0;

    assign bus_if.rdy_b = (ram_cnt == 0);
    assign bus_if.out_b = ram_rdata;

    always @(posedge clk) begin
        int idx;
        idx = int'(bus_if.y_b) * 320 + int'(bus_if.x_b);
        if (pre_en) mem[pre_idx] <= pre_val;
        if (bus_if.write_b) begin
            if (idx < 64000) mem[idx] <= bus_if.in_b;
            ram_cnt <= 2;
        end else if (bus_if.read_b) begin
            if (idx < 64000) ram_rdata <= mem[idx];
            ram_cnt <= 2;
        end else if (ram_cnt != 0) begin
            ram_cnt <= ram_cnt - 1;
        end
    end

    // ---------------- monitor ----------------
    int wr_cyc[$], wr_x[$], wr_y[$], wr_d[$], rd_cyc[$], done_cyc[$];
    int n_acc = 0;
    int viol  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.write_b) begin
                wr_cyc.push_back(cyc);
                wr_x.push_back(int'(bus_if.x_b));
                wr_y.push_back(int'(bus_if.y_b));
                wr_d.push_back(int'(bus_if.in_b));
            end
            if (bus_if.read_b) rd_cyc.push_back(cyc);
            if (bus_if.done) done_cyc.push_back(cyc);
            if (bus_if.cmd_valid && bus_if.cmd_ready) n_acc++;
            if ((bus_if.write_b || bus_if.read_b) && !bus_if.rdy_b) viol++;
            if (bus_if.write_b && bus_if.read_b) viol++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_cyc.delete(); wr_x.delete(); wr_y.delete(); wr_d.delete();
        rd_cyc.delete(); done_cyc.delete();
        n_acc = 0;
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input int op, output int k);
        clear_log();
        @(posedge clk); #1;
        bus_if.cmd_x0    = 9'(x0);
        bus_if.cmd_y0    = 8'(y0);
        bus_if.cmd_x1    = 9'(x1);
        bus_if.cmd_y1    = 8'(y1);
        bus_if.cmd_op    = 2'(op);
        bus_if.cmd_valid = 1'b1;
        k = cyc;
        chk("accept_ready", 32'(bus_if.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cyc.size() > 0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pre_set(input int x, input int y, input logic v);
        @(posedge clk); #1;
        pre_idx = y * 320 + x; pre_val = v; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // expected 2x2 walk for (2,1)-(3,2), shared by the straight and swapped cases
    task automatic chk_2x2(input string tag, input int k);
        int ex[4];
        int ey[4];
        ex = '{2, 3, 2, 3};
        ey = '{1, 1, 2, 2};
        chk({tag, "_nwr"}, 32'(wr_cyc.size()), 32'd4);
        chk({tag, "_nrd"}, 32'(rd_cyc.size()), 32'd0);
        if (wr_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_wcyc"}, 32'(wr_cyc[i] - k), 32'(1 + 3 * i));
                chk({tag, "_wx"},   32'(wr_x[i]), 32'(ex[i]));
                chk({tag, "_wy"},   32'(wr_y[i]), 32'(ey[i]));
                chk({tag, "_wd"},   32'(wr_d[i]), 32'd1);
            end
        end
        if (done_cyc.size() > 0) chk({tag, "_done"}, 32'(done_cyc[0] - k), 32'd13);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int sx[4];
        int sy[4];
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_x0 = '0; bus_if.cmd_y0 = '0;
        bus_if.cmd_x1 = '0; bus_if.cmd_y1 = '0;
        bus_if.cmd_op = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
        chk("rst_busy",  32'(bus_if.busy),      32'd0);
        chk("rst_done",  32'(bus_if.done),      32'd0);
        chk("rst_rd",    32'(bus_if.read_b),    32'd0);
        chk("rst_wr",    32'(bus_if.write_b),   32'd0);
        chk("rst_x",     32'(bus_if.x_b),       32'd0);
        chk("rst_y",     32'(bus_if.y_b),       32'd0);
        chk("rst_in",    32'(bus_if.in_b),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: set (2,1)-(3,2)
        send(2, 1, 3, 2, 1, k);
        chk("s1_busy", 32'(bus_if.busy), 32'd1);
        wait_done(60);
        chk_2x2("s1", k);
        chk("s1_mem", 32'(mem[2 * 320 + 3]), 32'd1);

        // 2: swapped corners give the identical walk
        send(3, 2, 2, 1, 1, k);
        wait_done(60);
        chk_2x2("s2", k);

        // 3: clamped clear at the bottom-right corner
        pre_set(319, 199, 1'b1);
        send(318, 198, 400, 255, 0, k);
        wait_done(60);
        sx = '{318, 319, 318, 319};
        sy = '{198, 198, 199, 199};
        chk("s3_nwr", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("s3_wx", 32'(wr_x[i]), 32'(sx[i]));
                chk("s3_wy", 32'(wr_y[i]), 32'(sy[i]));
                chk("s3_wd", 32'(wr_d[i]), 32'd0);
            end
        end
        chk("s3_mem", 32'(mem[199 * 320 + 319]), 32'd0);

        // 4: invert single pixel holding 1, then invert back
        pre_set(5, 5, 1'b1);
        send(5, 5, 5, 5, 2, k);
        wait_done(60);
        chk("s4_nrd", 32'(rd_cyc.size()), 32'd1);
        chk("s4_nwr", 32'(wr_cyc.size()), 32'd1);
        if (rd_cyc.size() == 1) chk("s4_rcyc", 32'(rd_cyc[0] - k), 32'd1);
        if (wr_cyc.size() == 1) begin
            chk("s4_wcyc", 32'(wr_cyc[0] - k), 32'd4);
            chk("s4_wd",   32'(wr_d[0]), 32'd0);
            chk("s4_wx",   32'(wr_x[0]), 32'd5);
        end
        if (done_cyc.size() > 0) chk("s4_done", 32'(done_cyc[0] - k), 32'd7);
        chk("s4_mem0", 32'(mem[5 * 320 + 5]), 32'd0);
        send(5, 5, 5, 5, 2, k);
        wait_done(60);
        if (wr_cyc.size() == 1) chk("s4b_wd", 32'(wr_d[0]), 32'd1);
        chk("s4b_mem1", 32'(mem[5 * 320 + 5]), 32'd1);

        // 5: reset in the middle of a 10x10 set
        send(0, 0, 9, 9, 1, k);
        repeat (20) @(posedge clk);
        #1;
        chk("s5_busy_mid", 32'(bus_if.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("s5_ready", 32'(bus_if.cmd_ready), 32'd1);
        chk("s5_busy",  32'(bus_if.busy),      32'd0);
        chk("s5_wr",    32'(bus_if.write_b),   32'd0);
        chk("s5_rd",    32'(bus_if.read_b),    32'd0);
        chk("s5_x",     32'(bus_if.x_b),       32'd0);
        chk("s5_y",     32'(bus_if.y_b),       32'd0);
        chk("s5_in",    32'(bus_if.in_b),      32'd0);
        chk("s5_done",  32'(bus_if.done),      32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("s5_nodone", 32'(done_cyc.size()), 32'd0);
        send(7, 7, 7, 7, 1, k);
        wait_done(60);
        chk("s5_nwr", 32'(wr_cyc.size()), 32'd1);
        if (wr_cyc.size() == 1) begin
            chk("s5_wcyc", 32'(wr_cyc[0] - k), 32'd1);
            chk("s5_wx",   32'(wr_x[0]), 32'd7);
        end
        if (done_cyc.size() > 0) chk("s5_dcyc", 32'(done_cyc[0] - k), 32'd4);

        // 6a: reserved op is a no-op that completes one cycle after accept
        send(1, 1, 4, 4, 3, k);
        wait_done(20);
        chk("s6_nwr", 32'(wr_cyc.size()), 32'd0);
        chk("s6_nrd", 32'(rd_cyc.size()), 32'd0);
        if (done_cyc.size() > 0) chk("s6_done", 32'(done_cyc[0] - k), 32'd1);

        // 6b: cmd_valid held through the whole command, dropped after done
        clear_log();
        @(posedge clk); #1;
        bus_if.cmd_x0 = 9'd20; bus_if.cmd_y0 = 8'd20;
        bus_if.cmd_x1 = 9'd20; bus_if.cmd_y1 = 8'd20;
        bus_if.cmd_op = 2'd1;
        bus_if.cmd_valid = 1'b1;
        k = cyc;
        repeat (5) @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        wait_done(20);
        repeat (4) @(posedge clk);
        #1;
        chk("s6b_acc", 32'(n_acc), 32'd1);
        chk("s6b_nwr", 32'(wr_cyc.size()), 32'd1);
        chk("s6b_ndone", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) chk("s6b_dcyc", 32'(done_cyc[0] - k), 32'd4);

        // request rule held throughout
        chk("req_rule", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
